// File: rtl/sram_bank_ctrl.sv
// Multi-bank single-port SRAM with a zero-fill clear sequence after reset, byte-masked writes
// and a fixed-latency read response. Define SRAM_OUTREG_EN to add a registered output stage.
module sram_bank #(
    parameter int BW_DATA = 64,
    parameter int ROWS    = 32,
    parameter int BW_ROW  = 5
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [BW_ROW-1:0]    wr_row,
    input  logic [BW_DATA/8-1:0] wr_be,
    input  logic [BW_DATA-1:0]   wr_data,
    input  logic [BW_ROW-1:0]    rd_row,
    output logic [BW_DATA-1:0]   rd_data
);
    logic [BW_DATA-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < BW_DATA/8; k++) begin
                if (wr_be[k]) mem[wr_row][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    assign rd_data = mem[rd_row];
endmodule

module sram_bank_ctrl #(
    parameter int BW_DATA  = 64,
    parameter int BW_ADDR  = 6,
    parameter int NUM_BANK = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wen,
    input  logic [BW_ADDR-1:0]   i_req_addr,
    input  logic [BW_DATA-1:0]   i_req_data,
    input  logic [BW_DATA/8-1:0] i_req_be,
    output logic                 o_rsp_valid,
    output logic [BW_DATA-1:0]   o_rsp_data,
    output logic                 o_init_done
);
    localparam int BW_BE   = BW_DATA / 8;
    localparam int ROWS    = (2 ** BW_ADDR) / NUM_BANK;
    localparam int BW_BANK = $clog2(NUM_BANK);
    localparam int BW_SEL  = (BW_BANK > 0) ? BW_BANK : 1;
    localparam int BW_ROW  = (ROWS > 1) ? $clog2(ROWS) : 1;
`ifdef SRAM_OUTREG_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 1;
`endif

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    logic [0:0]        state;
    logic [BW_ROW-1:0] cnt;
    logic              run;
    logic              clearing;
    logic              acc;
    logic [BW_ROW-1:0] row;
    logic [BW_SEL-1:0] sel;

    assign run         = (state == S_RUN);
    assign o_req_ready = run;
    assign o_init_done = run;
    assign clearing    = (state == S_CLEAR) && !i_rst;
    assign acc         = i_req_valid && run && !i_rst;
    assign row         = BW_ROW'(i_req_addr >> BW_BANK);
    assign sel         = BW_SEL'(i_req_addr & BW_ADDR'(NUM_BANK - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_CLEAR;
            cnt   <= '0;
        end else if (state == S_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == BW_ROW'(ROWS - 1)) state <= S_RUN;
        end
    end

    // Clear writes every bank at once; a normal write only touches the selected bank.
    logic [BW_ROW-1:0]                 wr_row;
    logic [BW_BE-1:0]                  wr_be;
    logic [BW_DATA-1:0]                wr_data;
    logic [BW_ROW-1:0]                 rd_row;
    logic [BW_SEL-1:0]                 rd_sel;
    logic [NUM_BANK-1:0][BW_DATA-1:0]  bank_rd;

    assign wr_row  = clearing ? cnt : row;
    assign wr_be   = clearing ? '1 : i_req_be;
    assign wr_data = clearing ? '0 : i_req_data;

    for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
        logic wr_en;
        assign wr_en = clearing || (acc && i_req_wen && (sel == BW_SEL'(b)));
        sram_bank #(
            .BW_DATA (BW_DATA),
            .ROWS    (ROWS),
            .BW_ROW  (BW_ROW)
        ) u_bank (
            .clk     (i_clk),
            .wr_en   (wr_en),
            .wr_row  (wr_row),
            .wr_be   (wr_be),
            .wr_data (wr_data),
            .rd_row  (rd_row),
            .rd_data (bank_rd[b])
        );
    end

    // Read address is latched at accept; the array is sampled one edge later, so a
    // write accepted on that same edge cannot leak into an older read.
    logic [STAGES:0]              vld_pipe;
    logic [STAGES:1][BW_DATA-1:0] dat_pipe;

    always_ff @(posedge i_clk) begin
        if (acc && !i_req_wen) begin
            rd_row <= row;
            rd_sel <= sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            vld_pipe <= '0;
            dat_pipe <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], acc && !i_req_wen};
            if (vld_pipe[0]) dat_pipe[1] <= bank_rd[rd_sel];
            for (int s = 2; s <= STAGES; s++) begin
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign o_rsp_valid = vld_pipe[STAGES];
    assign o_rsp_data  = dat_pipe[STAGES];
endmodule

// File: doc/sram_bank_ctrl.md
# sram_bank_ctrl

Parametrised, multi-bank, single-port SRAM block with a valid/ready request interface, per-byte write enables and a fixed-latency read response. On reset, a self-clear state machine zero-fills every row. The block then accepts one read or write per cycle. It is the next-generation memory macro for the OJT datapath and replaces the flat `wen`-only SRAM wherever masked writes or a guaranteed-clean memory are needed.

## Interface
Parameters:
- BW_DATA, 64, data width in bits; must be a multiple of 8.
- BW_ADDR, 6, word address width; total depth is 2^BW_ADDR words.
- NUM_BANK, 2, bank count; power of 2, at least 1, and no more than 2^BW_ADDR.
- Derived: BW_BE = BW_DATA/8; ROWS = 2^BW_ADDR / NUM_BANK.

Ports:
- i_clk  in  1  clock; all logic acts on the rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  block can accept a request.
- i_req_wen  in  1  1 = write, 0 = read.
- i_req_addr  in  BW_ADDR  word address.
- i_req_data  in  BW_DATA  write data.
- i_req_be  in  BW_BE  byte enables; bit k enables data[8k+7:8k].
- o_rsp_valid  out  1  read data valid (single-cycle pulse per read).
- o_rsp_data  out  BW_DATA  read data.
- o_init_done  out  1  high once the clear sequence has completed.

## Operation
- Bank select is i_req_addr[log2(NUM_BANK)-1:0]. Row is i_req_addr[BW_ADDR-1:log2(NUM_BANK)]. When NUM_BANK = 1, the whole address is the row.
- Each bank is a ROWS x BW_DATA register array with per-byte write.
- FSM has two states, S_CLEAR and S_RUN.
  - Reset enters S_CLEAR with the row counter at 0.
  - In S_CLEAR, each cycle writes all-zero to row[cnt] in every bank in parallel, then increments cnt.
  - After the write of row ROWS-1, the FSM moves to S_RUN.
  - S_RUN is held until the next reset.
- o_req_ready = (state == S_RUN). o_init_done = (state == S_RUN).
- A request is accepted on a rising edge where i_req_valid && o_req_ready.
- Requests presented during S_CLEAR are ignored. No memory side effect and no response.
- Accepted write: only the enabled byte lanes of the addressed word are updated. be = 0 is a legal no-op. Writes produce no response.
- Accepted read: exactly one o_rsp_valid pulse with the word's data. Responses stay in request order.
- There is no response backpressure; the consumer must always sink responses.
- A read accepted on the cycle after a write to the same address returns the new data.
- o_rsp_data holds the last read value between responses.
- Reset values: o_req_ready 0, o_init_done 0, o_rsp_valid 0, o_rsp_data 0. Memory contents are undefined until the clear finishes.
- Reset mid-operation:
  - The clear restarts from row 0.
  - An in-flight read response is dropped; o_rsp_valid is forced low.
  - Partial clear progress is discarded.

## Timing
- Reset release: i_rst is sampled low at edge E0. Clear writes occur at edges E0 through E(ROWS-1). o_req_ready rises after edge E(ROWS-1), so it is high during cycle ROWS.
- Default parameters give ROWS = 32, so 32 clear cycles.
- Throughput: one request per cycle, reads and writes freely mixed. There is no bank-conflict stall because the port is single and requests are serialised.
- Read latency (macro off): the read is accepted at edge N; o_rsp_valid and o_rsp_data are valid after edge N+1 for one cycle.
- Write effect: the write is accepted at edge N and is visible to a read accepted at edge N+1.

## Configuration
- SRAM_OUTREG_EN defined:
  - Adds a registered output stage after the bank read mux.
  - Read latency becomes 2: valid after edge N+2.
  - o_rsp_valid is delayed identically.
  - Reset clears both pipeline stages.
- SRAM_OUTREG_EN undefined: read latency is 1, as above.
- Throughput and ordering are unchanged in both modes.

## Test plan
- Clear sequence: hold i_rst 3 cycles, then release. Required: o_req_ready and o_init_done are low for exactly 32 cycles, then high. A read of address 0x05 returns 0x0000000000000000.
- Full write/read: write 0x2A with data 0x0123456789ABCDEF and be 0xFF, then read 0x2A. Required: one o_rsp_valid pulse, latency 1 (2 with SRAM_OUTREG_EN), data 0x0123456789ABCDEF.
- Byte mask: following the previous test, write 0x2A with data 0xFFFFFFFFFFFFFFFF and be 0x0F, then read. Required: 0x01234567FFFFFFFF.
- Streaming and interleave: back-to-back writes to addresses 0..63 with data = addr * 0x1111, then 64 back-to-back reads. Required: 64 responses in consecutive cycles, in order, each matching.
- Clear-phase ignore: drive a write of 0x3 with data 0xDEAD and be 0xFF during S_CLEAR. Required: no effect; a read of 0x3 after init returns 0.
- Reset mid-op: write 0x10 with data 0xAA, issue a read of 0x10, and assert i_rst on the next cycle. Required: o_rsp_valid never pulses; after re-clear, a read of 0x10 returns 0.
